// File: rtl/irq_pkg.sv
// irq_pkg
// Shared definitions for the interrupt controller slice: the FSM state
// encodings used by irq_ctrl and the vector-width helper used by both
// irq_ctrl and irq_prio_enc.
package irq_pkg;

  // FSM state encodings (plain constants so older tools can read them)
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  // Width of a source index: max(1, clog2(n))
  function automatic int vec_w(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc
// Combinational priority encoder over NUM_SRC request lines. The search
// starts at index 'start' and walks upward with wraparound; the first set
// request found wins. With start tied to zero this is plain lowest-index
// priority.
// Ports:
//   req   - request vector, one bit per source
//   start - index where the search begins (must be < NUM_SRC)
//   valid - at least one request is set
//   idx   - index of the winning request (0 when valid is low)
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int VEC_W   = vec_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [VEC_W-1:0]   start,
  output logic               valid,
  output logic [VEC_W-1:0]   idx
);

  int pos;

  // Walk the offsets from farthest to nearest so that the candidate closest
  // to 'start' is the last one written and therefore the one that sticks.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      pos = (int'(start) + k) % NUM_SRC;
      if (req[pos]) begin
        valid = 1'b1;
        idx   = VEC_W'(pos);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl
// Vectored interrupt controller for timer-class peripherals using a
// done/done_ack handshake. Done levels are sampled into a pending register,
// masked, arbitrated and presented to the CPU as irq/irq_vec. On irq_ack the
// chosen source gets a one-cycle src_ack pulse and the controller stays
// in-service until irq_eoi. No nesting.
// Build option: define IRQ_RR_EN for rotating priority (search starts one
// past the last serviced source); otherwise lowest index always wins.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   src_done    - per-source done levels
//   src_ack     - per-source done_ack pulses
//   mask_we     - mask write strobe, mask_wdata new mask, mask_q current mask
//   irq/irq_vec - request and source index to the CPU
//   irq_ack     - CPU accepts the request
//   irq_eoi     - CPU end-of-interrupt
//   in_service  - an ISR is active
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int               NUM_SRC  = 4,
  parameter logic [NUM_SRC-1:0] MASK_RST = '0,
  localparam int              VEC_W    = vec_w(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_done,
  output logic [NUM_SRC-1:0] src_ack,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic [NUM_SRC-1:0] mask_q,
  output logic               irq,
  output logic [VEC_W-1:0]   irq_vec,
  input  logic               irq_ack,
  input  logic               irq_eoi,
  output logic               in_service
);

  logic [1:0]         state;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] ack_hold;
  logic [NUM_SRC-1:0] req;
  logic [VEC_W-1:0]   start;
  logic               sel_valid;
  logic [VEC_W-1:0]   sel_idx;

  assign req = pending & mask_q;

`ifdef IRQ_RR_EN
  logic [VEC_W-1:0] rr_ptr;

  // Rotating pointer: one past the source just acknowledged, wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (state == ST_REQ && irq_ack) begin
      rr_ptr <= (irq_vec == VEC_W'(NUM_SRC - 1)) ? '0 : irq_vec + VEC_W'(1);
    end
  end

  assign start = rr_ptr;
`else
  assign start = '0;
`endif

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .VEC_W   (VEC_W)
  ) u_prio (
    .req   (req),
    .start (start),
    .valid (sel_valid),
    .idx   (sel_idx)
  );

  // Pending capture. A source is blocked for the ack cycle and the one after
  // it, giving the peripheral time to clear its registered done level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      ack_hold <= '0;
    end else begin
      pending  <= src_done & ~src_ack & ~ack_hold;
      ack_hold <= src_ack;
    end
  end

  // Mask register; the new value steers selection from the cycle it is visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= MASK_RST;
    end else if (mask_we) begin
      mask_q <= mask_wdata;
    end
  end

  // Request/service FSM. The vector is latched on entry to REQ and held
  // through SERVICE; an ack in REQ beats a simultaneous withdrawal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      irq        <= 1'b0;
      irq_vec    <= '0;
      src_ack    <= '0;
      in_service <= 1'b0;
    end else begin
      src_ack <= '0;
      case (state)
        ST_IDLE: begin
          if (sel_valid) begin
            irq_vec <= sel_idx;
            irq     <= 1'b1;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            src_ack    <= NUM_SRC'(1) << irq_vec;
            irq        <= 1'b0;
            in_service <= 1'b1;
            state      <= ST_SERVICE;
          end else if (!req[irq_vec]) begin
            irq   <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_SERVICE: begin
          if (irq_eoi) begin
            in_service <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          irq        <= 1'b0;
          in_service <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl
// Directed bench for irq_ctrl (NUM_SRC=4, MASK_RST=0). Inputs change and
// outputs are sampled 1 time unit after each rising clock edge.
// Build option: IRQ_RR_EN selects the rotating-priority expectations.
module tb_irq_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] src_done;
  logic [3:0] src_ack;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic [3:0] mask_q;
  logic       irq;
  logic [1:0] irq_vec;
  logic       irq_ack;
  logic       irq_eoi;
  logic       in_service;

  int checks;
  int errors;

  irq_ctrl #(
    .NUM_SRC  (4),
    .MASK_RST (4'b0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_done   (src_done),
    .src_ack    (src_ack),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask_q     (mask_q),
    .irq        (irq),
    .irq_vec    (irq_vec),
    .irq_ack    (irq_ack),
    .irq_eoi    (irq_eoi),
    .in_service (in_service)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts one comparison and reports it if observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Writes the mask through the strobe, taking one clock
  task automatic applyStimulus(input logic [3:0] mask_val);
    mask_we    = 1'b1;
    mask_wdata = mask_val;
    tick();
    mask_we    = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_vec;
    bit         seen;

    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    src_done   = '0;
    mask_we    = 1'b0;
    mask_wdata = '0;
    irq_ack    = 1'b0;
    irq_eoi    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    checkOutput("rst_irq", irq, 1'b0);
    checkOutput("rst_vec", irq_vec, 2'd0);
    checkOutput("rst_ack", src_ack, 4'b0000);
    checkOutput("rst_insvc", in_service, 1'b0);
    checkOutput("rst_mask", mask_q, 4'b0000);

    // Single source 2
    applyStimulus(4'b1111);
    checkOutput("mask_wr", mask_q, 4'b1111);
    src_done = 4'b0100;
    tick();
    checkOutput("single_lat1", irq, 1'b0);
    tick();
    checkOutput("single_irq", irq, 1'b1);
    checkOutput("single_vec", irq_vec, 2'd2);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checkOutput("single_ack", src_ack, 4'b0100);
    checkOutput("single_insvc", in_service, 1'b1);
    checkOutput("single_irq_off", irq, 1'b0);
    src_done = 4'b0000;
    tick();
    checkOutput("single_ack_pulse", src_ack, 4'b0000);
    checkOutput("single_vec_hold", irq_vec, 2'd2);
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    checkOutput("single_eoi", in_service, 1'b0);
    tick();
    tick();
    checkOutput("single_idle", irq, 1'b0);

    // Fixed priority: sources 1 and 3
    src_done = 4'b1010;
    tick();
    tick();
    checkOutput("prio_irq", irq, 1'b1);
    checkOutput("prio_vec1", irq_vec, 2'd1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checkOutput("prio_ack1", src_ack, 4'b0010);
    src_done = 4'b1000;
    tick();
    checkOutput("prio_no_nest", irq, 1'b0);
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    tick();
    checkOutput("prio_irq3", irq, 1'b1);
    checkOutput("prio_vec3", irq_vec, 2'd3);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checkOutput("prio_ack3", src_ack, 4'b1000);
    src_done = 4'b0000;
    irq_eoi  = 1'b1;
    tick();
    irq_eoi = 1'b0;
    tick();
    tick();

    // Mask blocks a source, then enabling it raises irq
    applyStimulus(4'b0000);
    src_done = 4'b0001;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (irq) seen = 1'b1;
    end
    checkOutput("mask_block", seen, 1'b0);
    applyStimulus(4'b0001);
    tick();
    checkOutput("mask_en_irq", irq, 1'b1);
    checkOutput("mask_en_vec", irq_vec, 2'd0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checkOutput("mask_ack", src_ack, 4'b0001);
    src_done = 4'b0000;
    irq_eoi  = 1'b1;
    tick();
    irq_eoi = 1'b0;
    tick();

    // Withdrawal by masking while in REQ
    applyStimulus(4'b1111);
    src_done = 4'b0100;
    tick();
    tick();
    checkOutput("wd_irq", irq, 1'b1);
    checkOutput("wd_vec", irq_vec, 2'd2);
    applyStimulus(4'b0000);
    tick();
    checkOutput("wd_drop", irq, 1'b0);
    checkOutput("wd_noack", src_ack, 4'b0000);
    tick();
    checkOutput("wd_idle", irq, 1'b0);
    checkOutput("wd_insvc", in_service, 1'b0);

    // Ack arriving in the cycle the request has already withdrawn
    applyStimulus(4'b1111);
    tick();
    checkOutput("col_irq", irq, 1'b1);
    src_done = 4'b0000;
    tick();
    checkOutput("col_still_req", irq, 1'b1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checkOutput("col_ack", src_ack, 4'b0100);
    checkOutput("col_insvc", in_service, 1'b1);

    // Asynchronous reset while in SERVICE
    rst = 1'b1;
    #1;
    checkOutput("ar_irq", irq, 1'b0);
    checkOutput("ar_vec", irq_vec, 2'd0);
    checkOutput("ar_ack", src_ack, 4'b0000);
    checkOutput("ar_insvc", in_service, 1'b0);
    checkOutput("ar_mask", mask_q, 4'b0000);
    tick();
    rst = 1'b0;
    tick();

    // Two sources held high; each ack followed by a delayed eoi
    applyStimulus(4'b1111);
    src_done = 4'b0011;
    for (int n = 0; n < 4; n++) begin
`ifdef IRQ_RR_EN
      exp_vec = (n % 2 == 0) ? 2'd0 : 2'd1;
`else
      exp_vec = 2'd0;
`endif
      seen = 1'b0;
      for (int w = 0; w < 10 && !seen; w++) begin
        tick();
        if (irq) seen = 1'b1;
      end
      checkOutput("seq_irq", seen, 1'b1);
      checkOutput("seq_vec", irq_vec, 32'(exp_vec));
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      tick();
      tick();
      tick();
      irq_eoi = 1'b1;
      tick();
      irq_eoi = 1'b0;
    end
    src_done = 4'b0000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
